// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared writeback types and default sizing
// for the ButterFly RV32IM integer writeback path.
package butterfly_pkg;

    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of mul/div writeback requests with
// wrapping pointers and full entry visibility for hazard masks.
module wb_fifo
    import butterfly_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                push_i,
    input  wb_req_t             data_i,
    input  logic                pop_i,
    output wb_req_t             head_o,
    output logic [CW-1:0]       count_o,
    output wb_req_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]    valid_o
);

    wb_req_t [DEPTH-1:0] mem_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;

    // storage: write the tail slot on push
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // slot i is live when its distance from the head is below count
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = {1'b0, AW'(i) - rd_ptr_q} < count_q;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and mul/div writebacks onto one registered
// regfile port. Define BUTTERFLY_WB_PERF_EN to build the perf counters.
module wb_arbiter
    import butterfly_pkg::*;
#(
    parameter int DEPTH        = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        md_valid_i,
    output logic        md_ready_o,
    input  logic [4:0]  md_rd_i,
    input  logic [31:0] md_data_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] busy_mask_o,
    output logic        stall_o,
    output logic [31:0] perf_md_writes_o,
    output logic [31:0] perf_stall_cycles_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    wb_req_t             head;
    wb_req_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]    valid;
    logic [CW-1:0]       count;
    logic                fifo_empty;
    logic                pipe_sel;
    logic                push;
    logic                pop;
    logic                out_md_q;
    logic [SW-1:0]       starve_q;

    assign fifo_empty = (count == '0);
    assign md_ready_o = (count < CW'(DEPTH));
    assign pipe_sel   = wb_valid_i && (wb_rd_i != 5'd0);
    assign pop        = !pipe_sel && !fifo_empty;
    assign push       = md_valid_i && md_ready_o && (md_rd_i != 5'd0);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push_i   (push),
        .data_i   ({md_rd_i, md_data_i}),
        .pop_i    (pop),
        .head_o   (head),
        .count_o  (count),
        .entries_o(entries),
        .valid_o  (valid)
    );

    // registered write port; address/data hold while idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_we_o   <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
            out_md_q  <= 1'b0;
        end else begin
            rd_we_o  <= pipe_sel || pop;
            out_md_q <= pop;
            if (pipe_sel) begin
                rd_addr_o <= wb_rd_i;
                rd_data_o <= wb_data_i;
            end else if (pop) begin
                rd_addr_o <= head.rd;
                rd_data_o <= head.data;
            end
        end
    end

    // starvation: stall after STARVE_LIMIT blocked head cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
            stall_o  <= 1'b0;
        end else if (pop || fifo_empty) begin
            starve_q <= '0;
            stall_o  <= 1'b0;
        end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
            stall_o  <= 1'b1;
        end else begin
            starve_q <= starve_q + SW'(1);
        end
    end

    // hazard mask over queued and in-flight mul/div targets
    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) busy_mask_o[entries[i].rd] = 1'b1;
        end
        if (out_md_q) busy_mask_o[rd_addr_o] = 1'b1;
    end

`ifdef BUTTERFLY_WB_PERF_EN
    logic [31:0] perf_md_q;
    logic [31:0] perf_stall_q;

    // retired mul/div writes and stalled cycles, wrapping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_md_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop)     perf_md_q    <= perf_md_q + 32'd1;
            if (stall_o) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_md_writes_o    = perf_md_q;
    assign perf_stall_cycles_o = perf_stall_q;
`else
    assign perf_md_writes_o    = '0;
    assign perf_stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
    // pipeline must hold off writebacks while stalled
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(stall_o && wb_valid_i));
`endif

endmodule
